// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared registered ALU, with an in-order response FIFO.
// Latency: grant at t, ALU result captured at end of t+1, response visible at t+2 when the FIFO is empty.
// Backpressure: grants stop once buffered plus in-flight results reach RSP_DEPTH; rsp_ready only drains the FIFO.
module alu_arbiter #(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [9:0]           req_opcode,
    input  logic [5:0]           req_funct3,
    input  logic [13:0]          req_funct7,
    input  logic [63:0]          req_opd1,
    input  logic [63:0]          req_opd2,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic [4:0]           alu_opcode,
    output logic [2:0]           alu_funct3,
    output logic [6:0]           alu_funct7,
    output logic [31:0]          alu_opd1,
    output logic [31:0]          alu_opd2,
    input  logic [31:0]          alu_rslt,
    input  logic                 flush,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [31:0]          rsp_data
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } rsp_t;

    logic             prio;
    logic             infl_vld;
    logic             infl_id;
    logic [TAG_W-1:0] infl_tag;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    rsp_t             mem [RSP_DEPTH];
    rsp_t             head;
    logic             credit;
    logic             gnt_vld;
    logic             gnt_id;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The in-flight result already owns a FIFO slot, so it counts against the credit.
    assign credit = ({1'b0, count} + (CNT_W + 1)'(infl_vld)) < (CNT_W + 1)'(RSP_DEPTH);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = prio;
        if (rst_n && !flush && credit) begin
            if (req_valid[prio]) begin
                gnt_vld = 1'b1;
                gnt_id  = prio;
            end else if (req_valid[!prio]) begin
                gnt_vld = 1'b1;
                gnt_id  = !prio;
            end
        end
    end

    assign req_ready  = gnt_vld ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign alu_opcode = gnt_vld ? (gnt_id ? req_opcode[9:5]   : req_opcode[4:0])  : '0;
    assign alu_funct3 = gnt_vld ? (gnt_id ? req_funct3[5:3]   : req_funct3[2:0])  : '0;
    assign alu_funct7 = gnt_vld ? (gnt_id ? req_funct7[13:7]  : req_funct7[6:0])  : '0;
    assign alu_opd1   = gnt_vld ? (gnt_id ? req_opd1[63:32]   : req_opd1[31:0])   : '0;
    assign alu_opd2   = gnt_vld ? (gnt_id ? req_opd2[63:32]   : req_opd2[31:0])   : '0;

    assign push      = infl_vld && !flush;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready && !flush;
    assign head      = mem[rd_ptr];
    assign rsp_id    = rsp_valid ? head.id   : 1'b0;
    assign rsp_tag   = rsp_valid ? head.tag  : '0;
    assign rsp_data  = rsp_valid ? head.data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            infl_vld <= 1'b0;
            infl_id  <= 1'b0;
            infl_tag <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            infl_vld <= gnt_vld && !flush;
            infl_id  <= gnt_id;
            infl_tag <= gnt_id ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
            if (gnt_vld) begin
                prio <= !gnt_id;
            end
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (!push && pop) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{id: infl_id, tag: infl_tag, data: alu_rslt};
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_alu_arbiter;

    localparam int TAG_W = 4;
    localparam int DEPTH = 3;
    localparam logic [4:0] OP_R = 5'b01100;
    localparam logic [4:0] OP_I = 5'b00100;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req_valid = '0;
    logic [1:0]         req_ready;
    logic [9:0]         req_opcode = '0;
    logic [5:0]         req_funct3 = '0;
    logic [13:0]        req_funct7 = '0;
    logic [63:0]        req_opd1 = '0;
    logic [63:0]        req_opd2 = '0;
    logic [2*TAG_W-1:0] req_tag = '0;
    logic [4:0]         alu_opcode;
    logic [2:0]         alu_funct3;
    logic [6:0]         alu_funct7;
    logic [31:0]        alu_opd1;
    logic [31:0]        alu_opd2;
    logic [31:0]        alu_rslt = '0;
    logic               flush = 1'b0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic               rsp_id;
    logic [TAG_W-1:0]   rsp_tag;
    logic [31:0]        rsp_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        int               due;
    } exp_t;

    alu_arbiter #(.TAG_W(TAG_W), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_opd1(req_opd1), .req_opd2(req_opd2), .req_tag(req_tag),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_opd1(alu_opd1), .alu_opd2(alu_opd2), .alu_rslt(alu_rslt),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0: r = (op == OP_R && f7[5]) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (f7[5]) r = $signed(a) >>> b[4:0];
                else       r = a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // The shared ALU: registers its operands and presents the result one cycle later.
    always @(posedge clk) alu_rslt <= alu_ref(alu_opcode, alu_funct3, alu_funct7, alu_opd1, alu_opd2);

    function automatic logic [31:0] ref_of(input int i);
        return alu_ref(req_opcode[i*5 +: 5], req_funct3[i*3 +: 3], req_funct7[i*7 +: 7],
                       req_opd1[i*32 +: 32], req_opd2[i*32 +: 32]);
    endfunction

    task automatic set_req(input int i, input logic [4:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag);
        req_opcode[i*5 +: 5]      = op;
        req_funct3[i*3 +: 3]      = f3;
        req_funct7[i*7 +: 7]      = f7;
        req_opd1[i*32 +: 32]      = a;
        req_opd2[i*32 +: 32]      = b;
        req_tag[i*TAG_W +: TAG_W] = tag;
    endtask

    task automatic rand_req(input int i);
        set_req(i, ($urandom_range(0, 1) != 0) ? OP_R : OP_I, 3'($urandom_range(0, 7)),
                {1'b0, 1'($urandom_range(0, 1)), 5'b0}, $urandom, $urandom, TAG_W'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        flush = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rand_req(0);
        rand_req(1);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b exp 00", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_data} !== '0) begin
            errors++; $display("FAIL reset_rsp got v=%b id=%b tag=%h data=%h exp all zero",
                               rsp_valid, rsp_id, rsp_tag, rsp_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL first_grant got %b exp 01", req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, OP_R, 3'd0, 7'd0, 32'd5, 32'd7, 4'd3);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_gnt got %b exp 01", req_ready);
        end
        checks++;
        if ({alu_opcode, alu_funct3, alu_funct7, alu_opd1, alu_opd2} !== {OP_R, 3'd0, 7'd0, 32'd5, 32'd7}) begin
            errors++; $display("FAIL single_alu got op=%h a=%h b=%h exp op=%h a=5 b=7",
                               alu_opcode, alu_opd1, alu_opd2, OP_R);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_early got %b exp 0", rsp_valid);
        end
        checks++;
        if ({alu_opcode, alu_funct3, alu_funct7, alu_opd1, alu_opd2} !== '0) begin
            errors++; $display("FAIL idle_alu_zero got a=%h b=%h exp 0", alu_opd1, alu_opd2);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_data} !== {1'b1, 1'b0, 4'd3, 32'd12}) begin
            errors++; $display("FAIL single_rsp got v=%b id=%b tag=%h data=%h exp v=1 id=0 tag=3 data=c",
                               rsp_valid, rsp_id, rsp_tag, rsp_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_drained got %b exp 0", rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        exp_t q[$];
        exp_t e;
        do_reset();
        rsp_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            req_valid = (n < 12) ? 2'b11 : 2'b00;
            rand_req(0);
            rand_req(1);
            #1;
            if (n < 12) begin
                checks++;
                if (req_ready !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL contend_gnt n=%0d got %b exp %b", n, req_ready,
                                       (n % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            checks++;
            if (rsp_valid !== (q.size() > 0 && n >= 2 && n < 14)) begin
                errors++; $display("FAIL contend_vld n=%0d got %b", n, rsp_valid);
            end
            if (rsp_valid && q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({rsp_id, rsp_tag, rsp_data} !== {e.id, e.tag, e.data}) begin
                    errors++; $display("FAIL contend_rsp got id=%b tag=%h data=%h exp id=%b tag=%h data=%h",
                                       rsp_id, rsp_tag, rsp_data, e.id, e.tag, e.data);
                end
            end
            if (n < 12) begin
                e.id = (n % 2 == 1);
                e.tag = req_tag[int'(e.id)*TAG_W +: TAG_W];
                e.data = ref_of(int'(e.id));
                e.due = 0;
                q.push_back(e);
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL contend_left got %0d exp 0", q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        int got = 0;
        do_reset();
        rsp_ready = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (n == 6) rsp_ready = 1'b1;
            req_valid = (n < 8) ? 2'b01 : 2'b00;
            rand_req(0);
            #1;
            if (n < 8) begin
                checks++;
                if (req_ready !== ((n < 3 || n == 7) ? 2'b01 : 2'b00)) begin
                    errors++; $display("FAIL bp_gnt n=%0d got %b exp %b", n, req_ready,
                                       (n < 3 || n == 7) ? 2'b01 : 2'b00);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra got id=%b data=%h exp none", rsp_id, rsp_data);
                end else begin
                    e = q.pop_front();
                    got++;
                    if ({rsp_id, rsp_tag, rsp_data} !== {e.id, e.tag, e.data}) begin
                        errors++; $display("FAIL bp_rsp got tag=%h data=%h exp tag=%h data=%h",
                                           rsp_tag, rsp_data, e.tag, e.data);
                    end
                end
            end
            if (req_ready[0]) begin
                e.id = 1'b0;
                e.tag = req_tag[TAG_W-1:0];
                e.data = ref_of(0);
                e.due = 0;
                q.push_back(e);
            end
            @(negedge clk);
        end
        checks++;
        if (got != 4 || q.size() != 0) begin
            errors++; $display("FAIL bp_count got %0d left %0d exp 4 left 0", got, q.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, OP_R, 3'd0, 7'h20, 32'd10, 32'd3, 4'd5);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01 || alu_funct7 !== 7'h20) begin
            errors++; $display("FAIL flush_issue got rdy=%b f7=%h exp 01 20", req_ready, alu_funct7);
        end
        @(negedge clk);
        req_valid = 2'b11;
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL flush_ready got %b exp 00", req_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        req_valid = 2'b00;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL flush_ghost n=%0d got %b data=%h exp 0", n, rsp_valid, rsp_data);
            end
            @(negedge clk);
        end
        set_req(1, OP_R, 3'd0, 7'd0, 32'd1, 32'd2, 4'd9);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL flush_after_gnt got %b exp 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_data} !== {1'b1, 1'b1, 4'd9, 32'd3}) begin
            errors++; $display("FAIL flush_after_rsp got v=%b id=%b tag=%h data=%h exp 1 1 9 3",
                               rsp_valid, rsp_id, rsp_tag, rsp_data);
        end
        @(negedge clk);
        // Two results parked in the FIFO, then flushed.
        rsp_ready = 1'b0;
        set_req(0, OP_I, 3'd6, 7'd0, 32'hf0, 32'h0f, 4'd1);
        req_valid = 2'b01;
        @(negedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL flush_buffered got %b exp 1", rsp_valid);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL flush_fifo n=%0d got %b exp 0", n, rsp_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rsp_ready = 1'b0;
        rand_req(0);
        rand_req(1);
        req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre got %b exp 1", rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL areset_now got v=%b rdy=%b exp 0 00", rsp_valid, req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL areset_stale n=%0d got %b exp 0", n, rsp_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int pref = 0;
        logic [1:0] exp_rdy;
        logic exp_vld;
        logic [78:0] exp_alu;
        int gi;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            rand_req(0);
            rand_req(1);
            if (cyc < 470) begin
                req_valid = 2'($urandom_range(0, 3));
                rsp_ready = ($urandom_range(0, 3) != 0);
                flush = ($urandom_range(0, 39) == 0);
            end else begin
                req_valid = 2'b00;
                rsp_ready = 1'b1;
                flush = 1'b0;
            end
            #1;
            exp_rdy = 2'b00;
            if (!flush && q.size() < DEPTH) begin
                if (req_valid[pref]) exp_rdy[pref] = 1'b1;
                else if (req_valid[1-pref]) exp_rdy[1-pref] = 1'b1;
            end
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_gnt cyc=%0d got %b exp %b", cyc, req_ready, exp_rdy);
            end
            gi = exp_rdy[1] ? 1 : 0;
            exp_alu = (exp_rdy == 2'b00) ? '0 :
                      {req_opcode[gi*5 +: 5], req_funct3[gi*3 +: 3], req_funct7[gi*7 +: 7],
                       req_opd1[gi*32 +: 32], req_opd2[gi*32 +: 32]};
            checks++;
            if ({alu_opcode, alu_funct3, alu_funct7, alu_opd1, alu_opd2} !== exp_alu) begin
                errors++; $display("FAIL rand_alu cyc=%0d got %h exp %h", cyc,
                                   {alu_opcode, alu_funct3, alu_funct7, alu_opd1, alu_opd2}, exp_alu);
            end
            exp_vld = (q.size() > 0) && (q[0].due <= cyc);
            checks++;
            if (rsp_valid !== exp_vld) begin
                errors++; $display("FAIL rand_vld cyc=%0d got %b exp %b", cyc, rsp_valid, exp_vld);
            end else if (exp_vld) begin
                checks++;
                if ({rsp_id, rsp_tag, rsp_data} !== {q[0].id, q[0].tag, q[0].data}) begin
                    errors++; $display("FAIL rand_rsp cyc=%0d got id=%b tag=%h data=%h exp id=%b tag=%h data=%h",
                                       cyc, rsp_id, rsp_tag, rsp_data, q[0].id, q[0].tag, q[0].data);
                end
            end else begin
                checks++;
                if ({rsp_id, rsp_tag, rsp_data} !== '0) begin
                    errors++; $display("FAIL rand_idle cyc=%0d got id=%b tag=%h data=%h exp 0",
                                       cyc, rsp_id, rsp_tag, rsp_data);
                end
            end
            if (flush) begin
                q.delete();
            end else if (exp_vld && rsp_ready) begin
                void'(q.pop_front());
            end
            if (exp_rdy != 2'b00) begin
                e.id = (gi == 1);
                e.tag = req_tag[gi*TAG_W +: TAG_W];
                e.data = ref_of(gi);
                e.due = cyc + 2;
                q.push_back(e);
                pref = 1 - gi;
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rand_drain got left=%0d v=%b exp 0 0", q.size(), rsp_valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
